secuenciador_melodia: RTL and testbench
=======================================

Name: secuenciador_melodia

Overview:
Plays a melody by sequencing the frequency divider (divisor_frecuencia) of the music box. The block fetches note words from an external synchronous melody ROM and drives the divider's signed 32-bit freq input for a programmed number of tempo ticks. It inserts a silent articulation gap between notes. It supports start, stop and loop control and reports busy/done to the top-level controller.

Parameters:
TICK_DIV, 500000, clock cycles per tempo tick (10 ms at 50 MHz); the bench overrides it with 4.
GAP_TICKS, 1, ticks of silence (freq=0) after each note; 0 disables the gap.
ADDR_W, 8, melody ROM address width.

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to start playback from address 0
stop  input  1  one-cycle request to abort playback
loop_en  input  1  on end marker, restart from address 0 instead of finishing
rom_addr  output  ADDR_W  melody ROM address, registered
rom_data  input  25  ROM word, valid one cycle after rom_addr: [24]=end, [23:8]=freq Hz, [7:0]=duration in ticks
freq  output  32 signed  frequency to divisor_frecuencia; 0 = silence
busy  output  1  high whenever the state is not IDLE
done  output  1  one-cycle pulse when the melody finishes normally

Behaviour:
- The clock and reset are fixed: one clock, clk; rst_n is asynchronous and active-low.
- Reset values: state IDLE, rom_addr 0, freq 0, busy 0, done 0, tick counter 0, duration counter 0, gap counter 0.
- States: IDLE, FETCH, LOAD, PLAY, GAP, DONE.
- IDLE:
  - start=1 and stop=0: rom_addr<=0, go to FETCH.
  - start is ignored in every other state.
- FETCH: lasts one cycle while the ROM responds. Go to LOAD. freq holds its previous value.
- LOAD: sample rom_data and decide:
  - end=1 with loop_en=1 and rom_addr!=0: rom_addr<=0, go to FETCH.
  - end=1 otherwise (an end marker at address 0 never loops): go to DONE.
  - duration=0: skip the entry; rom_addr<=rom_addr+1, go to FETCH.
  - Otherwise: freq<={16'b0, freq field}; load the duration counter; clear the tick counter; go to PLAY.
- PLAY: freq is held constant.
  - The tick counter counts 0..TICK_DIV-1; a tick fires at TICK_DIV-1, then the counter wraps to 0.
  - Each tick decrements the duration counter.
  - On the tick where the duration counter equals 1:
    - GAP_TICKS>0: freq<=0, load the gap counter, go to GAP.
    - GAP_TICKS=0: rom_addr<=rom_addr+1, go to FETCH.
  - A note therefore drives freq for exactly duration*TICK_DIV cycles.
- GAP: freq=0 for GAP_TICKS*TICK_DIV cycles, then rom_addr<=rom_addr+1, go to FETCH.
- Address wrap: incrementing past 2^ADDR_W-1 is treated as an end marker and follows the end=1 rules above. rom_addr wraps to 0.
- DONE: lasts one cycle. freq<=0, done=1, then go to IDLE. busy is 0 from the next cycle.
- stop has priority over every condition except reset:
  - On the next edge: state IDLE, freq 0, busy 0, rom_addr 0.
  - No done pulse is issued.
  - If stop and start are asserted in the same cycle, stop wins.
- Counters: the tick counter is wide enough for TICK_DIV-1 (clog2). Duration and gap counters are 8 bits. There is no underflow because duration 0 is skipped.
- Timing between notes: there are 2 cycles of fetch overhead per note (FETCH, LOAD), during which freq keeps its last value. This overhead is not part of the timed duration.

Decomposition:
- Shared header secuenciador_defs.vh holds:
  - state encodings (3 bits);
  - ROM word field positions: END_BIT=24, FREQ_MSB=23, FREQ_LSB=8, DUR_MSB=7, DUR_LSB=0.
- One sub-module: generador_tick.
  - Parameter: TICK_DIV.
  - Inputs: clk, rst_n, clr.
  - Output: tick, a one-cycle pulse every TICK_DIV cycles, restarted by clr.

Test Plan:
(All scenarios run with TICK_DIV=4, GAP_TICKS=1 and a ROM model with one-cycle latency. ROM A = {0: 1174 Hz, dur 3; 1: 880 Hz, dur 2; 2: end}.)
1. Reset: assert rst_n=0 mid-PLAY -> freq, busy, done and rom_addr go to 0 immediately (asynchronously); all remain 0 after release until start.
2. ROM A, loop_en=0, pulse start -> the sequence below, then a one-cycle done=1 followed by busy=0. rom_addr visits 0, 1, 2.
   - freq=1174 for 12 cycles
   - freq=0 for 4 cycles
   - freq=880 for 8 cycles
   - freq=0 for 4 cycles
3. ROM A, loop_en=1 -> after the end word at address 2, rom_addr returns to 0 and freq=1174 again. No done pulse over 3 iterations.
4. Stop during the 880 Hz note -> the next cycle has freq=0, busy=0 and no done pulse. A later start replays from address 0 with 1174 Hz.
5. ROM {0: 440 Hz, dur 0; 1: 660 Hz, dur 1; 2: end} -> 440 never appears on freq; 660 is driven for 4 cycles. A separate ROM {0: end} with loop_en=1 -> done pulses within 4 cycles, with no hang.
6. start pulsed mid-note -> ignored; freq timing is unchanged. start and stop in the same cycle from IDLE -> remains IDLE with busy=0.

Source files
------------

// File: rtl/secuenciador_melodia_pkg.sv
// secuenciador_melodia_pkg: shared state encoding and melody ROM word layout
package secuenciador_melodia_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;
  localparam int END_BIT  = 24;
  localparam int FREQ_MSB = 23;
  localparam int FREQ_LSB = 8;
  localparam int DUR_MSB  = 7;
  localparam int DUR_LSB  = 0;
endpackage

// File: rtl/secuenciador_melodia_generador_tick.sv
// generador_tick: one-cycle tempo tick every TICK_DIV cycles, restarted by clr
module generador_tick #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = !clr && cnt_q == CW'(TICK_DIV - 1);
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/secuenciador_melodia.sv
// secuenciador_melodia: steps through melody ROM words, driving freq per note with a silent gap
module secuenciador_melodia
  import secuenciador_melodia_pkg::*;
#(
  parameter int TICK_DIV  = 500000,
  parameter int GAP_TICKS = 1,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [24:0]       rom_data,
  output logic signed [31:0] freq,
  output logic              busy,
  output logic              done
);
  state_t state_q, state_d, adv_state;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic signed [31:0] freq_q, freq_d;
  logic [7:0] dur_q, dur_d, gap_q, gap_d;
  logic tick, w_end;
  logic [15:0] w_freq;
  logic [7:0] w_dur;
  assign w_end  = rom_data[END_BIT];
  assign w_freq = rom_data[FREQ_MSB:FREQ_LSB];
  assign w_dur  = rom_data[DUR_MSB:DUR_LSB];
  generador_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!(state_q == S_PLAY || state_q == S_GAP)),
    .tick (tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      freq_q  <= '0;
      dur_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      freq_q  <= freq_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
    end
  // advancing past the last address acts as an end marker at a nonzero address
  assign adv_state = (&addr_q && !loop_en) ? S_DONE : S_FETCH;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    freq_d  = freq_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        addr_d  = '0;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (w_end) begin
          state_d = (loop_en && addr_q != '0) ? S_FETCH : S_DONE;
          addr_d  = (loop_en && addr_q != '0) ? '0 : addr_q;
        end else if (w_dur == '0) begin
          state_d = adv_state;
          addr_d  = addr_q + 1'b1;
        end else begin
          freq_d  = {16'b0, w_freq};
          dur_d   = w_dur;
          state_d = S_PLAY;
        end
      end
      S_PLAY: if (tick) begin
        dur_d = dur_q - 1'b1;
        if (dur_q == 8'd1) begin
          if (GAP_TICKS > 0) begin
            freq_d  = '0;
            gap_d   = 8'(GAP_TICKS);
            state_d = S_GAP;
          end else begin
            state_d = adv_state;
            addr_d  = addr_q + 1'b1;
          end
        end
      end
      S_GAP: if (tick) begin
        gap_d = gap_q - 1'b1;
        if (gap_q == 8'd1) begin
          state_d = adv_state;
          addr_d  = addr_q + 1'b1;
        end
      end
      S_DONE: begin
        freq_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (stop) begin
      state_d = S_IDLE;
      freq_d  = '0;
      addr_d  = '0;
    end
  end
  always_comb begin
    rom_addr = addr_q;
    freq     = freq_q;
    busy     = state_q != S_IDLE;
    done     = state_q == S_DONE;
  end
endmodule

// File: tb/tb_secuenciador_melodia.sv
// tb_secuenciador_melodia: cycle-accurate trace check against a note-list model of the melody
module tb_secuenciador_melodia;
  localparam int TD  = 4;
  localparam int GAP = 1;
  logic clk = 0, rst_n = 0, start = 0, stop = 0, loop_en = 0;
  logic [7:0] rom_addr;
  logic [24:0] rom_data;
  logic signed [31:0] freq;
  logic busy, done;
  logic [24:0] rom [256];
  int total = 0, bad = 0;
  typedef struct {int f; int a; bit b; bit d;} exp_t;
  exp_t exp_q[$];

  secuenciador_melodia #(.TICK_DIV(TD), .GAP_TICKS(GAP), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .freq(freq), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [24:0] w(input bit e, input int f, input int d);
    return {e, 16'(f), 8'(d)};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = w(1, 0, 0);
  endtask

  task automatic push(input int f, input int a, input bit b, input bit d);
    exp_t e;
    e.f = f; e.a = a; e.b = b; e.d = d;
    exp_q.push_back(e);
  endtask

  // expected per-cycle trace starting with the cycle after the start edge
  task automatic build(input bit lp, input int n);
    int addr = 0, pf = 0;
    logic [24:0] x;
    exp_q.delete();
    while (exp_q.size() < n) begin
      push(pf, addr, 1, 0);
      push(pf, addr, 1, 0);
      x = rom[addr];
      if (x[24]) begin
        if (lp && addr != 0) begin addr = 0; continue; end
        push(pf, addr, 1, 1);
        while (exp_q.size() < n) push(0, addr, 0, 0);
        break;
      end
      if (x[7:0] == 0) begin addr = (addr + 1) % 256; continue; end
      repeat (int'(x[7:0]) * TD) push(int'(x[23:8]), addr, 1, 0);
      repeat (GAP * TD) push(0, addr, 1, 0);
      pf = GAP > 0 ? 0 : int'(x[23:8]);
      addr = (addr + 1) % 256;
    end
  endtask

  task automatic play_check(input string name, input bit lp, input int n, input int again);
    loop_en = lp;
    build(lp, n);
    @(negedge clk); start = 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = (i == again);
      total++;
      if (freq !== exp_q[i].f || rom_addr !== 8'(exp_q[i].a) || busy !== exp_q[i].b || done !== exp_q[i].d) begin
        bad++;
        $display("FAIL %s cyc=%0d got f=%0d a=%0d b=%0b d=%0b exp f=%0d a=%0d b=%0b d=%0b",
                 name, i, freq, rom_addr, busy, done, exp_q[i].f, exp_q[i].a, exp_q[i].b, exp_q[i].d);
      end
    end
    start = 0;
  endtask

  task automatic do_stop();
    @(negedge clk); stop = 1;
    @(negedge clk); stop = 0;
  endtask

  task automatic rom_a();
    clear_rom();
    rom[0] = w(0, 1174, 3); rom[1] = w(0, 880, 2); rom[2] = w(1, 0, 0);
  endtask

  task automatic check_idle(input string name);
    total++;
    if (freq !== 0 || busy !== 0 || done !== 0 || rom_addr !== 0) begin
      bad++;
      $display("FAIL %s got f=%0d b=%0b d=%0b a=%0d exp all 0", name, freq, busy, done, rom_addr);
    end
  endtask

  task automatic test_reset();
    #1 check_idle("reset_init");
    @(negedge clk); rst_n = 1;
    @(negedge clk); check_idle("reset_release");
    rom_a();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (6) @(negedge clk);
    total++;
    if (freq !== 1174) begin bad++; $display("FAIL reset_pre_play got f=%0d exp 1174", freq); end
    #2 rst_n = 0;
    #1 check_idle("reset_async");
    @(negedge clk); rst_n = 1;
    repeat (3) begin @(negedge clk); check_idle("reset_hold"); end
  endtask

  task automatic test_rom_a();
    rom_a();
    play_check("rom_a", 0, 42, -1);
  endtask

  task automatic test_loop();
    rom_a();
    play_check("loop", 1, 3 * 34 + 6, -1);
    do_stop();
    check_idle("loop_stop");
  endtask

  task automatic test_stop();
    int k = 0;
    rom_a();
    loop_en = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    while (freq !== 880 && k < 200) begin @(negedge clk); k++; end
    total++;
    if (freq !== 880) begin bad++; $display("FAIL stop_wait got f=%0d exp 880", freq); end
    stop = 1;
    @(negedge clk); stop = 0;
    check_idle("stop_next");
    repeat (5) begin
      @(negedge clk);
      total++;
      if (done !== 0 || busy !== 0) begin bad++; $display("FAIL stop_quiet got d=%0b b=%0b exp 0 0", done, busy); end
    end
    play_check("stop_replay", 0, 20, -1);
    repeat (30) @(negedge clk);
  endtask

  task automatic test_skip();
    clear_rom();
    rom[0] = w(0, 440, 0); rom[1] = w(0, 660, 1); rom[2] = w(1, 0, 0);
    play_check("skip", 0, 20, -1);
    clear_rom();
    play_check("end_at_0", 1, 6, -1);
  endtask

  task automatic test_start_ignored();
    rom_a();
    play_check("start_mid", 0, 42, 7);
    @(negedge clk); start = 1; stop = 1;
    @(negedge clk); start = 0; stop = 0;
    repeat (3) begin check_idle("start_stop"); @(negedge clk); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      int ne = $urandom_range(1, 6);
      bit lp = 1'($urandom_range(0, 1));
      clear_rom();
      for (int i = 0; i < ne; i++) rom[i] = w(0, $urandom_range(1, 65535), $urandom_range(0, 3));
      play_check("random", lp, 90, -1);
      if (busy) do_stop();
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_rom_a();
    test_loop();
    test_stop();
    test_skip();
    test_start_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
